// File: rtl/operand_loader_pkg.sv
// Shared phase encoding and default debounce length for the operand loader and the ALU top level.
package operand_loader_pkg;

  localparam logic [1:0] WAIT_A  = 2'd0;
  localparam logic [1:0] WAIT_B  = 2'd1;
  localparam logic [1:0] WAIT_OP = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/operand_loader_button_conditioner.sv
// Raw button -> 2-flop sync -> debounce -> registered one-cycle press pulse.
// Press pulse appears DEBOUNCE_CYCLES+2 edges after the first edge that samples the button high.
module button_conditioner
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips on the cycle the counter would reach DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = sync2_q;
      else                   cnt_d = cnt_q + 1'b1;
    end
    pulse_d = deb_d & ~deb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/operand_loader.sv
// Steps switch values into operand A, operand B and opcode registers on debounced load presses.
// Enables follow a load pulse by one cycle, exec_pulse follows en_op by one; clear wins over load.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       btn_load,
  input  logic       btn_clear,
  output logic [7:0] data_out,
  output logic       en_a,
  output logic       en_b,
  output logic       en_op,
  output logic       exec_pulse,
  output logic [1:0] state
);

  logic       load_pulse, clear_pulse;
  logic [1:0] state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       en_a_q, en_a_d, en_b_q, en_b_d, en_op_q, en_op_d;
  logic       exec_q, exec_d;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_cond (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_load),
    .pulse (load_pulse)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_cond (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clear),
    .pulse (clear_pulse)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    en_a_d  = 1'b0;
    en_b_d  = 1'b0;
    en_op_d = 1'b0;
    exec_d  = en_op_q;
    if (clear_pulse) begin
      state_d = WAIT_A;
      exec_d  = 1'b0;
    end else if (load_pulse) begin
      data_d = sw;
      case (state_q)
        WAIT_A:  begin state_d = WAIT_B;  en_a_d  = 1'b1; end
        WAIT_B:  begin state_d = WAIT_OP; en_b_d  = 1'b1; end
        WAIT_OP: begin state_d = DONE;    en_op_d = 1'b1; end
        default: begin state_d = WAIT_B;  en_a_d  = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_A;
      data_q  <= 8'h00;
      en_a_q  <= 1'b0;
      en_b_q  <= 1'b0;
      en_op_q <= 1'b0;
      exec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      en_a_q  <= en_a_d;
      en_b_q  <= en_b_d;
      en_op_q <= en_op_d;
      exec_q  <= exec_d;
    end
  end

  assign state      = state_q;
  assign data_out   = data_q;
  assign en_a       = en_a_q;
  assign en_b       = en_b_q;
  assign en_op      = en_op_q;
  assign exec_pulse = exec_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with DEBOUNCE_CYCLES=4.
module tb_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       btn_load, btn_clear;
  logic [7:0] data_out;
  logic       en_a, en_b, en_op, exec_pulse;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int cnt_a, cnt_b, cnt_op, cnt_ex, n_multi, op_cyc, ex_cyc;
  logic [7:0] dat_a, dat_b, dat_op;

  always #5 clk = ~clk;

  operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .btn_load   (btn_load),
    .btn_clear  (btn_clear),
    .data_out   (data_out),
    .en_a       (en_a),
    .en_b       (en_b),
    .en_op      (en_op),
    .exec_pulse (exec_pulse),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_watch();
    cnt_a = 0; cnt_b = 0; cnt_op = 0; cnt_ex = 0; n_multi = 0;
    op_cyc = -100; ex_cyc = -200;
    dat_a = 8'h00; dat_b = 8'h00; dat_op = 8'h00;
  endtask

  task automatic step_watch(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (en_a)       begin cnt_a++;  dat_a  = data_out; end
      if (en_b)       begin cnt_b++;  dat_b  = data_out; end
      if (en_op)      begin cnt_op++; dat_op = data_out; op_cyc = cyc; end
      if (exec_pulse) begin cnt_ex++; ex_cyc = cyc; end
      if ((int'(en_a) + int'(en_b) + int'(en_op) + int'(exec_pulse)) > 1) n_multi++;
    end
  endtask

  task automatic press_load(input logic [7:0] v, input int hold);
    sw = v;
    btn_load = 1'b1;
    step_watch(hold);
    btn_load = 1'b0;
    step_watch(12);
  endtask

  task automatic press_clear(input int hold);
    btn_clear = 1'b1;
    step_watch(hold);
    btn_clear = 1'b0;
    step_watch(12);
  endtask

  initial begin
    rst = 1'b1; sw = 8'h00; btn_load = 1'b0; btn_clear = 1'b0;
    clear_watch();
    tick(); tick();
    chk("rst_state", {30'd0, state}, 0);
    chk("rst_data", {24'd0, data_out}, 0);
    chk("rst_en", {28'd0, en_a, en_b, en_op, exec_pulse}, 0);
    rst = 1'b0;
    tick();

    // Latency: first edge sampling btn_load high is edge 1, en_a expected after edge 7.
    sw = 8'h3C; btn_load = 1'b1;
    for (int e = 1; e <= 6; e++) tick();
    chk("lat_e6_en_a", {31'd0, en_a}, 0);
    tick();
    chk("lat_e7_en_a", {31'd0, en_a}, 1);
    chk("lat_e7_data", {24'd0, data_out}, 32'h3C);
    chk("lat_e7_state", {30'd0, state}, 1);
    clear_watch();
    step_watch(8);
    btn_load = 1'b0;
    step_watch(12);
    chk("hold_no_extra", cnt_a + cnt_b + cnt_op + cnt_ex, 0);

    // Full sequence continues with B and opcode.
    clear_watch();
    press_load(8'hA5, 15);
    chk("seq_b_cnt", cnt_b, 1);
    chk("seq_b_data", {24'd0, dat_b}, 32'hA5);
    chk("seq_b_state", {30'd0, state}, 2);
    clear_watch();
    press_load(8'h02, 15);
    chk("seq_op_cnt", cnt_op, 1);
    chk("seq_op_data", {24'd0, dat_op}, 32'h02);
    chk("seq_ex_cnt", cnt_ex, 1);
    chk("seq_ex_after_op", ex_cyc - op_cyc, 1);
    chk("seq_state_done", {30'd0, state}, 3);
    chk("seq_data_hold", {24'd0, data_out}, 32'h02);
    chk("seq_onehot", n_multi, 0);

    // From DONE a load restarts with operand A.
    clear_watch();
    press_load(8'hFF, 15);
    chk("done_a_cnt", cnt_a, 1);
    chk("done_other", cnt_b + cnt_op + cnt_ex, 0);
    chk("done_a_data", {24'd0, dat_a}, 32'hFF);
    chk("done_state", {30'd0, state}, 1);
    sw = 8'h5A;
    step_watch(3);
    chk("data_hold_ff", {24'd0, data_out}, 32'hFF);

    // Clear mid-sequence after A and B.
    clear_watch();
    press_load(8'h11, 15);
    chk("clr_pre_state", {30'd0, state}, 2);
    clear_watch();
    press_clear(15);
    chk("clr_state", {30'd0, state}, 0);
    chk("clr_no_en", cnt_a + cnt_b + cnt_op + cnt_ex, 0);
    chk("clr_data_kept", {24'd0, data_out}, 32'h11);
    clear_watch();
    press_load(8'h22, 15);
    chk("clr_next_a", cnt_a, 1);
    chk("clr_next_data", {24'd0, dat_a}, 32'h22);

    // Glitch: three sampled high cycles then release.
    clear_watch();
    press_clear(15);
    chk("gl_pre_state", {30'd0, state}, 0);
    clear_watch();
    sw = 8'h77; btn_load = 1'b1;
    step_watch(3);
    btn_load = 1'b0;
    step_watch(15);
    chk("gl_no_en", cnt_a + cnt_b + cnt_op + cnt_ex, 0);
    chk("gl_state", {30'd0, state}, 0);
    clear_watch();
    press_load(8'h44, 40);
    chk("long_one_a", cnt_a, 1);
    chk("long_other", cnt_b + cnt_op + cnt_ex, 0);
    chk("long_state", {30'd0, state}, 1);

    // Simultaneous load and clear rising together.
    clear_watch();
    sw = 8'h99; btn_load = 1'b1; btn_clear = 1'b1;
    step_watch(15);
    btn_load = 1'b0; btn_clear = 1'b0;
    step_watch(12);
    chk("sim_state", {30'd0, state}, 0);
    chk("sim_no_en", cnt_a + cnt_b + cnt_op + cnt_ex, 0);
    chk("sim_data", {24'd0, data_out}, 32'h44);

    // Reset in the cycle between en_op and exec_pulse, load held through reset release.
    clear_watch();
    press_load(8'h01, 15);
    press_load(8'h02, 15);
    chk("rm_pre_state", {30'd0, state}, 2);
    sw = 8'h03; btn_load = 1'b1;
    for (int i = 0; i < 40 && !en_op; i++) tick();
    chk("rm_en_op_seen", {31'd0, en_op}, 1);
    rst = 1'b1;
    tick();
    chk("rm_outputs_reset", {18'd0, state, data_out, en_a, en_b, en_op, exec_pulse}, 0);
    rst = 1'b0;
    clear_watch();
    step_watch(15);
    btn_load = 1'b0;
    step_watch(12);
    chk("rm_no_exec", cnt_ex, 0);
    chk("rm_repress_a", cnt_a, 1);
    chk("rm_repress_data", {24'd0, dat_a}, 32'h03);
    chk("rm_state", {30'd0, state}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
